// File: rtl/sound_bus_arbiter.sv
// Sound-CPU RAM port arbiter: hands the 64 KB sound RAM between the Z80 and the host upload path.
// Optional forced takeover on missing BUSAK is enabled by defining SND_ARB_BUSAK_TIMEOUT_EN.
module sound_bus_arbiter #(
    parameter int RESET_HOLD    = 16,
    parameter int BUSAK_TIMEOUT = 4096
) (
    input  logic        CLK_32M,
    input  logic        reset_n,
    input  logic        host_req,
    input  logic        host_sel,
    input  logic        host_rd,
    input  logic        host_wr,
    input  logic [15:0] host_addr,
    input  logic [7:0]  host_din,
    output logic        host_grant,
    output logic        host_dout_valid,
    output logic [15:0] host_wr_count,
    input  logic [15:0] z80_addr,
    input  logic [7:0]  z80_dout,
    input  logic        z80_mreq_n,
    input  logic        z80_wr_n,
    input  logic        z80_busak_n,
    output logic        z80_busrq_n,
    output logic        z80_reset_n,
    output logic [15:0] ram_addr,
    output logic [7:0]  ram_data,
    output logic        ram_we,
    output logic        timeout_flag
);

    // state   | meaning
    // IDLE    | Z80 owns RAM, running
    // REQ     | BUSRQ asserted, Z80 still owns RAM until BUSAK
    // HOST    | host owns RAM, BUSRQ held
    // RELEASE | RAM back to Z80, Z80 held in reset for RESET_HOLD cycles
    typedef enum logic [1:0] {IDLE, REQ, HOST, RELEASE} state_t;

    localparam int HW = (RESET_HOLD < 2) ? 1 : $clog2(RESET_HOLD + 1);
    localparam logic [HW-1:0] HOLD_LOAD = HW'(RESET_HOLD);

    state_t        state;
    logic [HW-1:0] hold_cnt;
    logic          pending;

`ifdef SND_ARB_BUSAK_TIMEOUT_EN
    localparam int TW = (BUSAK_TIMEOUT < 2) ? 1 : $clog2(BUSAK_TIMEOUT);
    localparam logic [TW-1:0] REQ_LOAD = TW'(BUSAK_TIMEOUT - 1);
    logic [TW-1:0] req_cnt;
`else
    assign timeout_flag = 1'b0;
`endif

    always_comb begin
        if (host_grant) begin
            ram_addr = host_addr;
            ram_data = host_din;
            ram_we   = host_sel & host_wr;
        end else begin
            ram_addr = z80_addr;
            ram_data = z80_dout;
            ram_we   = ~z80_mreq_n & ~z80_wr_n;
        end
    end

    always_ff @(posedge CLK_32M or negedge reset_n) begin
        if (!reset_n) begin
            state           <= RELEASE;
            hold_cnt        <= HOLD_LOAD;
            pending         <= 1'b0;
            z80_busrq_n     <= 1'b1;
            z80_reset_n     <= 1'b0;
            host_grant      <= 1'b0;
            host_dout_valid <= 1'b0;
            host_wr_count   <= 16'h0000;
`ifdef SND_ARB_BUSAK_TIMEOUT_EN
            req_cnt         <= '0;
            timeout_flag    <= 1'b0;
`endif
        end else begin
            // RAM read is registered one cycle, so valid trails the strobe by one
            host_dout_valid <= host_grant & host_sel & host_rd;
            case (state)
                IDLE: begin
                    if (host_req) begin
                        state       <= REQ;
                        z80_busrq_n <= 1'b0;
`ifdef SND_ARB_BUSAK_TIMEOUT_EN
                        req_cnt     <= REQ_LOAD;
`endif
                    end
                end
                REQ: begin
                    if (!z80_busak_n) begin
                        state         <= HOST;
                        host_grant    <= 1'b1;
                        host_wr_count <= 16'h0000;
`ifdef SND_ARB_BUSAK_TIMEOUT_EN
                        timeout_flag  <= 1'b0;
`endif
                    end else if (!host_req) begin
                        state       <= IDLE;
                        z80_busrq_n <= 1'b1;
                    end
`ifdef SND_ARB_BUSAK_TIMEOUT_EN
                    else if (req_cnt == '0) begin
                        // Z80 never acknowledged: take the bus and keep it in reset
                        state         <= HOST;
                        host_grant    <= 1'b1;
                        host_wr_count <= 16'h0000;
                        z80_reset_n   <= 1'b0;
                        timeout_flag  <= 1'b1;
                    end else begin
                        req_cnt <= req_cnt - 1'b1;
                    end
`endif
                end
                HOST: begin
                    if (host_sel && host_wr)
                        host_wr_count <= host_wr_count + 16'h0001;
                    if (!host_req) begin
                        state       <= RELEASE;
                        host_grant  <= 1'b0;
                        z80_busrq_n <= 1'b1;
                        z80_reset_n <= 1'b0;
                        hold_cnt    <= HOLD_LOAD;
                    end
                end
                RELEASE: begin
                    if (host_req)
                        pending <= 1'b1;
                    if (hold_cnt <= HW'(1)) begin
                        pending     <= 1'b0;
                        z80_reset_n <= 1'b1;
                        if (pending || host_req) begin
                            state       <= REQ;
                            z80_busrq_n <= 1'b0;
`ifdef SND_ARB_BUSAK_TIMEOUT_EN
                            req_cnt     <= REQ_LOAD;
`endif
                        end else begin
                            state <= IDLE;
                        end
                    end else begin
                        hold_cnt <= hold_cnt - 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
